// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants and types for the ALU issue/control stage:
// ALU op codes, RV32I major opcodes, branch one-hot bit positions and
// the registered control bundle layout.
package alu_issue_ctrl_pkg;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_TGT   = 4'b0011;
    localparam logic [3:0] ALU_AND   = 4'b0100;
    localparam logic [3:0] ALU_OR    = 4'b0101;
    localparam logic [3:0] ALU_XOR   = 4'b0110;
    localparam logic [3:0] ALU_LUI   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_AUIPC = 4'b1010;
    localparam logic [3:0] ALU_SLL   = 4'b1100;
    localparam logic [3:0] ALU_SRL   = 4'b1101;
    localparam logic [3:0] ALU_SRA   = 4'b1110;

    // RV32I major opcodes
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Bit positions inside br_onehot = {bgeu,bltu,bge,blt,bne,beq}
    localparam int unsigned BR_BEQ  = 0;
    localparam int unsigned BR_BNE  = 1;
    localparam int unsigned BR_BLT  = 2;
    localparam int unsigned BR_BGE  = 3;
    localparam int unsigned BR_BLTU = 4;
    localparam int unsigned BR_BGEU = 5;

    // Decoded control fields held in the out slot and the skid slot
    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       alu_src;
        logic [2:0] funct3;
        logic [5:0] br_onehot;
        logic       jal;
        logic       jalr;
        logic       op_a_pc;
        logic       illegal;
    } ctrl_bundle_t;

    // Register/immediate arithmetic op from funct3; alt selects sub/sra
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Purely combinational RV32I instruction -> ALU control decode.
module alu_issue_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output logic [3:0]  alu_ctrl,
    output logic        alu_src,
    output logic [2:0]  funct3,
    output logic [5:0]  br_onehot,
    output logic        jal,
    output logic        jalr,
    output logic        op_a_pc,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       f7_alt;
    logic       unused_inst_bits;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7_alt = inst[30];
    assign funct3 = f3;

    // Register numbers and immediates are consumed by the ALU stage, not here
    assign unused_inst_bits = ^{inst[31], inst[29:15], inst[11:7]};

    // Opcode/funct decode into the control bundle fields
    always_comb begin
        alu_ctrl  = ALU_ADD;
        alu_src   = 1'b0;
        br_onehot = '0;
        jal       = 1'b0;
        jalr      = 1'b0;
        op_a_pc   = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OPC_R: begin
                alu_ctrl = arith_op(f3, f7_alt);
            end
            OPC_I: begin
                // funct7[5] is only meaningful for srai; addi never becomes sub
                alu_src  = 1'b1;
                alu_ctrl = arith_op(f3, f7_alt && (f3 == 3'b101));
            end
            OPC_LUI: begin
                alu_src  = 1'b1;
                alu_ctrl = ALU_LUI;
            end
            OPC_AUIPC: begin
                alu_src  = 1'b1;
                alu_ctrl = ALU_AUIPC;
                op_a_pc  = 1'b1;
            end
            OPC_LOAD, OPC_STORE: begin
                alu_src  = 1'b1;
                alu_ctrl = ALU_ADD;
            end
            OPC_BRANCH: begin
                alu_ctrl = ALU_TGT;
                case (f3)
                    3'b000:  br_onehot[BR_BEQ]  = 1'b1;
                    3'b001:  br_onehot[BR_BNE]  = 1'b1;
                    3'b100:  br_onehot[BR_BLT]  = 1'b1;
                    3'b101:  br_onehot[BR_BGE]  = 1'b1;
                    3'b110:  br_onehot[BR_BLTU] = 1'b1;
                    3'b111:  br_onehot[BR_BGEU] = 1'b1;
                    default: illegal            = 1'b1;
                endcase
            end
            OPC_JAL: begin
                alu_src  = 1'b1;
                alu_ctrl = ALU_TGT;
                jal      = 1'b1;
            end
            OPC_JALR: begin
                alu_src  = 1'b1;
                alu_ctrl = ALU_TGT;
                jalr     = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue/control stage: decodes RV32I instructions into the ALU control
// bundle, registers it behind a valid/ready handshake with a one-entry skid
// buffer, and turns a taken ALU jump_flag into a redirect pulse plus flush.
// Optional performance counters: define ALU_ISSUE_PERF_EN.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_ctrl,
    output logic            alu_src,
    output logic [2:0]      funct3,
    output logic [5:0]      br_onehot,
    output logic            jal,
    output logic            jalr,
    output logic            op_a_pc,
    output logic [XLEN-1:0] link_pc,
    output logic            illegal,
    input  logic            jump_flag,
    input  logic [XLEN-1:0] alu_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
`ifdef ALU_ISSUE_PERF_EN
   ,output logic [31:0]     perf_issued,
    output logic [31:0]     perf_taken,
    output logic [31:0]     perf_stall
`endif
);

    localparam logic STATE_RUN   = 1'b0;
    localparam logic STATE_FLUSH = 1'b1;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    ctrl_bundle_t    dec_bundle;
    logic [XLEN-1:0] new_link;

    logic            out_valid_q, out_valid_d;
    ctrl_bundle_t    out_bundle_q, out_bundle_d;
    logic [XLEN-1:0] out_link_q, out_link_d;
    logic            skid_valid_q, skid_valid_d;
    ctrl_bundle_t    skid_bundle_q, skid_bundle_d;
    logic [XLEN-1:0] skid_link_q, skid_link_d;
    logic            state_q, state_d;
    logic [2:0]      flush_cnt_q, flush_cnt_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic accept;
    logic out_fire;
    logic taken;

    alu_issue_decode u_decode (
        .inst      (in_inst),
        .alu_ctrl  (dec_bundle.alu_ctrl),
        .alu_src   (dec_bundle.alu_src),
        .funct3    (dec_bundle.funct3),
        .br_onehot (dec_bundle.br_onehot),
        .jal       (dec_bundle.jal),
        .jalr      (dec_bundle.jalr),
        .op_a_pc   (dec_bundle.op_a_pc),
        .illegal   (dec_bundle.illegal)
    );

    assign new_link = in_pc + XLEN'(4);

    // rst_n is folded in so in_ready is low throughout reset and high in
    // the very first cycle after release
    assign in_ready = rst_n && !skid_valid_q && (state_q == STATE_RUN);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;
    assign taken    = out_fire && jump_flag;

    // Next state for out slot, skid slot, flush FSM and redirect
    always_comb begin
        out_valid_d      = out_valid_q;
        out_bundle_d     = out_bundle_q;
        out_link_d       = out_link_q;
        skid_valid_d     = skid_valid_q;
        skid_bundle_d    = skid_bundle_q;
        skid_link_d      = skid_link_q;
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;

        if (taken) begin
            // Wrong-path work is dropped: out, skid and any same-cycle accept
            out_valid_d      = 1'b0;
            skid_valid_d     = 1'b0;
            state_d          = STATE_FLUSH;
            flush_cnt_d      = FLUSH_LOAD;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = alu_target;
        end else begin
            if (state_q == STATE_FLUSH) begin
                if (flush_cnt_q <= 3'd1) begin
                    state_d     = STATE_RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            if (out_fire || !out_valid_q) begin
                // Skid (older) refills out before any new input; accept is
                // impossible while the skid is full, so the skid just empties
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_bundle_d = skid_bundle_q;
                    out_link_d   = skid_link_q;
                    skid_valid_d = 1'b0;
                end else begin
                    out_valid_d = accept;
                    if (accept) begin
                        out_bundle_d = dec_bundle;
                        out_link_d   = new_link;
                    end
                end
            end else if (accept) begin
                skid_valid_d  = 1'b1;
                skid_bundle_d = dec_bundle;
                skid_link_d   = new_link;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q      <= 1'b0;
            out_bundle_q     <= '0;
            out_link_q       <= '0;
            skid_valid_q     <= 1'b0;
            skid_bundle_q    <= '0;
            skid_link_q      <= '0;
            state_q          <= STATE_RUN;
            flush_cnt_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            out_valid_q      <= out_valid_d;
            out_bundle_q     <= out_bundle_d;
            out_link_q       <= out_link_d;
            skid_valid_q     <= skid_valid_d;
            skid_bundle_q    <= skid_bundle_d;
            skid_link_q      <= skid_link_d;
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign alu_ctrl       = out_bundle_q.alu_ctrl;
    assign alu_src        = out_bundle_q.alu_src;
    assign funct3         = out_bundle_q.funct3;
    assign br_onehot      = out_bundle_q.br_onehot;
    assign jal            = out_bundle_q.jal;
    assign jalr           = out_bundle_q.jalr;
    assign op_a_pc        = out_bundle_q.op_a_pc;
    assign illegal        = out_bundle_q.illegal;
    assign link_pc        = out_link_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_taken_q, perf_taken_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Saturating event counters
    always_comb begin
        perf_issued_d = perf_issued_q;
        perf_taken_d  = perf_taken_q;
        perf_stall_d  = perf_stall_q;
        if (out_fire && (perf_issued_q != '1)) perf_issued_d = perf_issued_q + 32'd1;
        if (taken && (perf_taken_q != '1))     perf_taken_d  = perf_taken_q + 32'd1;
        if (in_valid && !in_ready && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q <= '0;
            perf_taken_q  <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_taken_q  <= perf_taken_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_taken  = perf_taken_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: queue-based reference model of the
// issue stage plus hand-computed literal expectations.
module tb_alu_issue_ctrl;

    localparam int XLEN         = 32;
    localparam int FLUSH_CYCLES = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_inst = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [3:0]      alu_ctrl;
    logic            alu_src;
    logic [2:0]      funct3;
    logic [5:0]      br_onehot;
    logic            jal;
    logic            jalr;
    logic            op_a_pc;
    logic [XLEN-1:0] link_pc;
    logic            illegal;
    logic            jump_flag = 1'b0;
    logic [XLEN-1:0] alu_target = '0;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_inst        (in_inst),
        .in_pc          (in_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .alu_ctrl       (alu_ctrl),
        .alu_src        (alu_src),
        .funct3         (funct3),
        .br_onehot      (br_onehot),
        .jal            (jal),
        .jalr           (jalr),
        .op_a_pc        (op_a_pc),
        .link_pc        (link_pc),
        .illegal        (illegal),
        .jump_flag      (jump_flag),
        .alu_target     (alu_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic        src;
        logic [2:0]  f3;
        logic [5:0]  br;
        logic        jal;
        logic        jalr;
        logic        pca;
        logic        ill;
        logic [31:0] link;
    } exp_t;

    // Reference model state: instructions held by the stage, oldest first
    exp_t        mq[$];
    int          flush_left = 0;
    logic        m_rv = 1'b0;
    logic [31:0] m_rpc = '0;
    logic        m_acc, m_fire, m_taken;
    exp_t        cmp_e;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Instruction semantics straight from the RV32I encoding tables
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t       e;
        logic [2:0] f3;
        logic [3:0] arith [8];
        int         brbit [8];
        arith = '{4'b0000, 4'b1100, 4'b1000, 4'b1001, 4'b0110, 4'b1101, 4'b0101, 4'b0100};
        brbit = '{0, 1, -1, -1, 2, 3, 4, 5};
        f3 = i[14:12];
        e.ctrl = 4'b0000; e.src = 1'b0; e.f3 = f3; e.br = '0;
        e.jal = 1'b0; e.jalr = 1'b0; e.pca = 1'b0; e.ill = 1'b0;
        e.link = pc + 32'd4;
        case (i[6:0])
            7'h33: begin
                if (i[30] && f3 == 3'd0)      e.ctrl = 4'b0001;
                else if (i[30] && f3 == 3'd5) e.ctrl = 4'b1110;
                else                          e.ctrl = arith[f3];
            end
            7'h13: begin
                e.src  = 1'b1;
                e.ctrl = (i[30] && f3 == 3'd5) ? 4'b1110 : arith[f3];
            end
            7'h37: begin e.src = 1'b1; e.ctrl = 4'b0111; end
            7'h17: begin e.src = 1'b1; e.ctrl = 4'b1010; e.pca = 1'b1; end
            7'h03, 7'h23: begin e.src = 1'b1; e.ctrl = 4'b0000; end
            7'h63: begin
                e.ctrl = 4'b0011;
                if (brbit[f3] < 0) e.ill = 1'b1;
                else               e.br  = 6'(1 << brbit[f3]);
            end
            7'h6F: begin e.src = 1'b1; e.ctrl = 4'b0011; e.jal = 1'b1; end
            7'h67: begin e.src = 1'b1; e.ctrl = 4'b0011; e.jalr = 1'b1; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic m_rdy();
        return rst_n && (mq.size() < 2) && (flush_left == 0);
    endfunction

    // Model update on each clock edge from the bench-driven inputs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            flush_left = 0;
            m_rv = 1'b0;
            m_rpc = '0;
        end else begin
            m_acc   = in_valid && m_rdy();
            m_fire  = (mq.size() > 0) && out_ready;
            m_taken = m_fire && jump_flag;
            m_rv    = m_taken;
            if (m_taken) begin
                m_rpc = alu_target;
                mq.delete();
                flush_left = FLUSH_CYCLES;
            end else begin
                if (flush_left > 0) flush_left--;
                if (m_fire) void'(mq.pop_front());
                if (m_acc) mq.push_back(ref_decode(in_inst, in_pc));
            end
        end
    end

    // Compare DUT against the model mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, m_rdy()});
            chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
            chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
            if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
            if (mq.size() > 0) begin
                cmp_e = mq[0];
                chk("m_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, cmp_e.ctrl});
                chk("m_alu_src", {31'd0, alu_src}, {31'd0, cmp_e.src});
                chk("m_funct3", {29'd0, funct3}, {29'd0, cmp_e.f3});
                chk("m_br_onehot", {26'd0, br_onehot}, {26'd0, cmp_e.br});
                chk("m_strobes", {28'd0, jal, jalr, op_a_pc, illegal},
                    {28'd0, cmp_e.jal, cmp_e.jalr, cmp_e.pca, cmp_e.ill});
                chk("m_link_pc", link_pc, cmp_e.link);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    logic [31:0] mix [14];

    initial begin
        mix = '{32'h000000B7, 32'h00000097, 32'h0000A083, 32'h0010A023,
                32'h0031B0B3, 32'h0031D0B3, 32'h4031D0B3, 32'h0000C063,
                32'h00002063, 32'h0031C0B3, 32'h0031E0B3, 32'h0031A0B3,
                32'h003110B3, 32'h0FF0F093};

        // Reset state
        #3;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_bundle", {alu_ctrl, alu_src, funct3, br_onehot, jal, jalr, op_a_pc, illegal}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // add, srai, addi-with-funct7 back to back
        out_ready = 1'b1;
        push(32'h003100B3, 32'h0);
        cyc();
        chk("add_out_valid", {31'd0, out_valid}, 32'd1);
        chk("add_ctrl", {28'd0, alu_ctrl}, 32'h0);
        chk("add_src", {31'd0, alu_src}, 32'd0);
        chk("add_illegal", {31'd0, illegal}, 32'd0);
        push(32'h4030D093, 32'h4);
        cyc();
        chk("srai_ctrl", {28'd0, alu_ctrl}, 32'hE);
        chk("srai_src", {31'd0, alu_src}, 32'd1);
        push(32'h40008093, 32'h8);
        cyc();
        chk("addi_ctrl", {28'd0, alu_ctrl}, 32'h0);
        chk("addi_src", {31'd0, alu_src}, 32'd1);
        in_valid = 1'b0;
        cyc();

        // Back-pressure: two accepted, third held until room
        out_ready = 1'b0;
        push(32'h003100B3, 32'h10);
        cyc();
        chk("bp_ready_after1", {31'd0, in_ready}, 32'd1);
        push(32'h403100B3, 32'h14);
        cyc();
        chk("bp_ready_after2", {31'd0, in_ready}, 32'd0);
        push(32'h0031F0B3, 32'h18);
        cyc();
        chk("bp_head_add", {28'd0, alu_ctrl}, 32'h0);
        out_ready = 1'b1;
        cyc();
        chk("bp_second_sub", {28'd0, alu_ctrl}, 32'h1);
        cyc();
        in_valid = 1'b0;
        chk("bp_third_and", {28'd0, alu_ctrl}, 32'h4);
        chk("bp_third_link", link_pc, 32'h1C);
        cyc();

        // Taken beq: redirect, same-cycle input dropped, one flush cycle
        push(32'h00000063, 32'h100);
        cyc();
        chk("beq_onehot", {26'd0, br_onehot}, 32'h01);
        push(32'h003100B3, 32'h104);
        jump_flag  = 1'b1;
        alu_target = 32'h140;
        cyc();
        jump_flag = 1'b0;
        in_valid  = 1'b0;
        chk("beq_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("beq_redirect_pc", redirect_pc, 32'h140);
        chk("beq_out_dropped", {31'd0, out_valid}, 32'd0);
        chk("beq_flush_ready", {31'd0, in_ready}, 32'd0);
        cyc();
        chk("beq_pulse_end", {31'd0, redirect_valid}, 32'd0);
        chk("beq_flush_done", {31'd0, in_ready}, 32'd1);

        // jal at top of address space, then taken with skid full
        out_ready = 1'b0;
        push(32'h0080006F, 32'hFFFFFFFC);
        cyc();
        chk("jal_link_wrap", link_pc, 32'h0);
        chk("jal_strobe", {31'd0, jal}, 32'd1);
        chk("jal_ctrl", {28'd0, alu_ctrl}, 32'h3);
        push(32'h00001063, 32'h0);
        cyc();
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        jump_flag  = 1'b1;
        alu_target = 32'h200;
        cyc();
        jump_flag = 1'b0;
        chk("jal_skid_dropped", {31'd0, out_valid}, 32'd0);
        chk("jal_redirect_pc", redirect_pc, 32'h200);
        cyc();

        // jump_flag without a fire must be ignored
        out_ready = 1'b0;
        jump_flag = 1'b1;
        push(32'h00108093, 32'h300);
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("nofire_no_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("nofire_held", {31'd0, out_valid}, 32'd1);
        jump_flag = 1'b0;
        out_ready = 1'b1;
        cyc();

        // Decode mix streamed at full rate
        foreach (mix[k]) begin
            push(mix[k], 32'h400 + 32'(k) * 32'd4);
            cyc();
        end
        in_valid = 1'b0;
        cyc();

        // Unsupported opcode
        push(32'h0000007F, 32'h500);
        cyc();
        in_valid = 1'b0;
        chk("bad_illegal", {31'd0, illegal}, 32'd1);
        chk("bad_ctrl", {28'd0, alu_ctrl}, 32'h0);
        cyc();

        // Taken jalr, then asynchronous reset in the middle of FLUSH
        out_ready = 1'b0;
        push(32'h00008067, 32'h600);
        cyc();
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        jump_flag  = 1'b1;
        alu_target = 32'h700;
        cyc();
        jump_flag = 1'b0;
        chk("jalr_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("arst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("arst_redirect_pc", redirect_pc, 32'd0);
        chk("arst_bundle", {alu_ctrl, alu_src, funct3, br_onehot, jal, jalr, op_a_pc, illegal}, 32'd0);
        chk("arst_link_pc", link_pc, 32'd0);
        #10 rst_n = 1'b1;
        #1 chk("arst_run_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/control stage between instruction decode and the combinational ALU.
- Decodes each RV32I instruction into the ALU control bundle: 4-bit op code, operand-B select, funct3, one-hot branch/jump strobes, operand-A-is-PC select.
- Holds the bundle in registered output slots behind a valid/ready handshake with a one-entry skid buffer.
- Watches the ALU's jump_flag to issue a PC redirect and flush wrong-path instructions.

Parameters:
- XLEN, 32, datapath width of PC and target.
- FLUSH_CYCLES, 1, cycles in_ready is held low after a taken redirect (1..7).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode presents instruction.
- in_ready  out  1  block can accept.
- in_inst  in  32  raw instruction.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  control bundle valid to ALU stage.
- out_ready  in  1  ALU stage consumes bundle.
- alu_ctrl  out  4  ALU op code.
- alu_src  out  1  1 = operand B is immediate.
- funct3  out  3  passed-through funct3.
- br_onehot  out  6  {bgeu,bltu,bge,blt,bne,beq}.
- jal  out  1  jal strobe.
- jalr  out  1  jalr strobe.
- op_a_pc  out  1  1 = operand A is PC (auipc).
- link_pc  out  XLEN  registered in_pc+4 for jal/jalr writeback.
- illegal  out  1  unsupported opcode.
- jump_flag  in  1  ALU taken indication for the bundle currently on out.
- alu_target  in  XLEN  ALU address result.
- redirect_valid  out  1  one-cycle redirect pulse.
- redirect_pc  out  XLEN  redirect target.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, skid empty, in_ready=0 while rst_n low, 1 in the first cycle after release. redirect_valid=0, redirect_pc=0, all bundle fields 0, state=RUN.
- ALU op codes:
  - 0000 add, 0001 sub, 0100 and, 0101 or, 0110 xor.
  - 1000 slt, 1001 sltu.
  - 1100 sll, 1101 srl, 1110 sra.
  - 0111 lui, 1010 auipc, 0011 branch/jump target.
- Decode by opcode:
  - 0110011 R-type: alu_src=0. funct7[5] selects sub/sra.
  - 0010011 I-type: alu_src=1. funct7[5] honoured only for srai; addi never becomes sub.
  - 0110111: lui. 0010111: auipc with op_a_pc=1.
  - 0000011 and 0100011 (load/store): add, alu_src=1.
  - 1100011: 0011, br_onehot from funct3. funct3 010/011 → illegal.
  - 1101111: jal=1, ctrl 0011. 1100111: jalr=1, ctrl 0011.
  - Any other opcode: ctrl 0000, all strobes 0, illegal=1.
- Latency: accepted instruction appears on out one cycle after in_valid&&in_ready when the out slot is free. No combinational path in→out.
- Skid buffer:
  - Accept while out_valid&&!out_ready moves the bundle into the skid; in_ready=!skid_full && state==RUN.
  - On out fire, skid refills out before any new input. Order is strictly preserved.
- Taken detection: fire = out_valid&&out_ready&&jump_flag. On fire:
  - Next cycle: redirect_valid=1 and redirect_pc=alu_target (registered).
  - Skid cleared, out_valid=0, and an input accepted in the fire cycle is discarded.
  - state→FLUSH.
- FLUSH: in_ready=0 for FLUSH_CYCLES cycles (counter), then →RUN. redirect_valid is high only in the first cycle.
- Simultaneous: jump_flag is ignored when the out slot does not fire. A taken fire with skid full still drops the skid.
- Reset mid-FLUSH: returns immediately to RUN reset values.
- link_pc arithmetic is modulo 2^XLEN.

Optional Feature:
- ALU_ISSUE_PERF_EN defined: adds output perf_issued (32), perf_taken (32) and perf_stall (32).
  - Saturating counters reset to 0: fired bundles, taken fires, cycles with in_valid&&!in_ready.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package holds: ALU op-code constants (the 13 codes above), RV32I opcode constants, and the br_onehot bit-index constants.
- One sub-module: alu_issue_decode (purely combinational inst→bundle). The FSM, skid and redirect logic stay in alu_issue_ctrl.

Test Plan:
- Reset released, push add x1,x2,x3 (0x003100B3) with out_ready=1 → next cycle out_valid=1, alu_ctrl=0000, alu_src=0, illegal=0.
- Push srai (0x4030D093) then addi with funct7 bit set (0x40008093) → alu_ctrl=1110 then 0000, alu_src=1 both.
- Hold out_ready=0, push 3 instructions → in_ready drops after 2 accepted. Release out_ready → bundles emerge in order, none lost.
- beq at pc 0x100 with jump_flag=1, alu_target=0x140 on fire → redirect_valid pulse with redirect_pc=0x140, skid and same-cycle input dropped, in_ready=0 for 1 cycle.
- jal at pc 0xFFFFFFFC → link_pc=0x00000000, jal=1, alu_ctrl=0011.
- Opcode 0x7F, and rst_n asserted mid-FLUSH → illegal=1/alu_ctrl=0000, and all outputs return to reset values asynchronously.
